// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// ALU codes, datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic state_t next_state(input state_t s, input logic [6:0] op);
        state_t n;
        n = FETCH;
        case (s)
            FETCH: n = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXECUTER;
                    OP_I:         n = EXECUTEI;
                    OP_JAL:       n = JAL;
                    OP_BEQ:       n = BEQ;
                    default:      n = FETCH;
                endcase
            end
            MEMADR:                   n = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:                  n = MEMWB;
            EXECUTER, EXECUTEI, JAL:  n = ALUWB;
            default:                  n = FETCH;
        endcase
        return n;
    endfunction

    // Moore control word for a state; fields not set stay 0 (alu_op = add).
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
            end
            MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] r;
        case (op)
            OP_SW:   r = IMM_S;
            OP_BEQ:  r = IMM_B;
            OP_JAL:  r = IMM_J;
            default: r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, state_o
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, state_o
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps alu_op and the instruction funct fields to alu_control.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // addi has no funct7, so only R-type (op[5]=1) can select sub
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RISC-V datapath; control word is
// registered alongside the state so outputs follow state without decode glitches.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_controller_if.master   bus
);
    state_t     r_state;
    ctrl_t      r_ctrl;
    state_t     w_next;
    logic [2:0] w_alu_control;

    assign w_next = next_state(r_state, bus.op);

    // Async reset lands directly on FETCH's control word, so no enable of the
    // interrupted state survives past the reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ctrl  <= state_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (r_ctrl.alu_op),
        .i_funct3      (bus.funct3),
        .i_op5         (bus.op[5]),
        .i_funct7b5    (bus.funct7b5),
        .o_alu_control (w_alu_control)
    );

    assign bus.pc_write    = r_ctrl.pc_update | (r_ctrl.branch & bus.zero);
    assign bus.adr_src     = r_ctrl.adr_src;
    assign bus.mem_write   = r_ctrl.mem_write;
    assign bus.ir_write    = r_ctrl.ir_write;
    assign bus.reg_write   = r_ctrl.reg_write;
    assign bus.result_src  = r_ctrl.result_src;
    assign bus.alu_src_a   = r_ctrl.alu_src_a;
    assign bus.alu_src_b   = r_ctrl.alu_src_b;
    assign bus.imm_src     = imm_src_of(bus.op);
    assign bus.alu_control = w_alu_control;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: the stimulus walks each
// instruction's state plan and queues expected outputs; a negedge monitor checks them.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] aluc;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_instr = 0;

    function automatic obs_t sample();
        obs_t g;
        g.st   = bus.state_o;
        g.pcw  = bus.pc_write;
        g.adr  = bus.adr_src;
        g.mw   = bus.mem_write;
        g.irw  = bus.ir_write;
        g.rw   = bus.reg_write;
        g.rs   = bus.result_src;
        g.sa   = bus.alu_src_a;
        g.sb   = bus.alu_src_b;
        g.imm  = bus.imm_src;
        g.aluc = bus.alu_control;
        return g;
    endfunction

    // Operation an R/I instruction asks of the ALU, by mnemonic.
    function automatic logic [2:0] arith_op(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic obs_t model(input state_t s, input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic z);
        obs_t e;
        e = '0;
        e.st = s;
        case (op)
            7'b0100011: e.imm = 2'b01;
            7'b1100011: e.imm = 2'b10;
            7'b1101111: e.imm = 2'b11;
            default:    e.imm = 2'b00;
        endcase
        e.aluc = 3'b000;
        case (s)
            FETCH:    begin e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.rs = 2'b10; end
            DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
            MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            MEMREAD:  begin e.adr = 1; end
            MEMWRITE: begin e.adr = 1; e.mw = 1; end
            MEMWB:    begin e.rs = 2'b01; e.rw = 1; end
            EXECUTER: begin e.sa = 2'b10; e.aluc = arith_op(op, f3, f7); end
            EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; e.aluc = arith_op(op, f3, f7); end
            ALUWB:    begin e.rw = 1; end
            JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            BEQ:      begin e.sa = 2'b10; e.aluc = 3'b001; e.pcw = z; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    // Monitor: one observed control vector per cycle while expectations are pending.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = sample();
                n_vec++;
                if (g !== e)
                    begin
                        n_bad++;
                        $display("FAIL cycle state=%0d: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b sa=%b sb=%b imm=%b aluc=%b, want st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b sa=%b sb=%b imm=%b aluc=%b",
                                 e.st, g.st, g.pcw, g.adr, g.mw, g.irw, g.rw, g.rs, g.sa, g.sb, g.imm, g.aluc,
                                 e.st, e.pcw, e.adr, e.mw, e.irw, e.rw, e.rs, e.sa, e.sb, e.imm, e.aluc);
                    end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
    // zmode: -1 random zero flag each cycle, otherwise that constant.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int zmode);
        state_t plan[$];
        logic   z;
        case (op)
            7'b0000011: plan = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
            7'b0100011: plan = '{FETCH, DECODE, MEMADR, MEMWRITE};
            7'b0110011: plan = '{FETCH, DECODE, EXECUTER, ALUWB};
            7'b0010011: plan = '{FETCH, DECODE, EXECUTEI, ALUWB};
            7'b1101111: plan = '{FETCH, DECODE, JAL, ALUWB};
            7'b1100011: plan = '{FETCH, DECODE, BEQ};
            default:    plan = '{FETCH, DECODE};
        endcase
        n_instr++;
        $display("instr %0d op=%b funct3=%b funct7b5=%b cycles=%0d", n_instr, op, f3, f7, plan.size());
        foreach (plan[k]) begin
            z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.op       = op;
            bus.funct3   = f3;
            bus.funct7b5 = f7;
            bus.zero     = z;
            exp_q.push_back(model(plan[k], op, f3, f7, z));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] o;
        case ($urandom_range(0, 6))
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1101111;
            5: o = 7'b1100011;
            default: begin
                do o = 7'($urandom);
                while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                       o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011);
            end
        endcase
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int budget;
        bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;

        // Reset held across edges shows FETCH outputs.
        repeat (3) @(posedge clk);
        #1;
        chk("reset state_o",    32'(bus.state_o),    32'd0);
        chk("reset ir_write",   32'(bus.ir_write),   32'd1);
        chk("reset pc_write",   32'(bus.pc_write),   32'd1);
        chk("reset result_src", 32'(bus.result_src), 32'd2);
        chk("reset alu_src_b",  32'(bus.alu_src_b),  32'd2);
        chk("reset mem_write",  32'(bus.mem_write),  32'd0);
        chk("reset reg_write",  32'(bus.reg_write),  32'd0);
        rst_n = 1'b1;

        run_instr(7'b0000011, 3'b010, 1'b0, -1);   // lw
        run_instr(7'b1100011, 3'b000, 1'b0, 1);    // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0);    // beq not taken
        run_instr(7'b0110011, 3'b000, 1'b1, -1);   // sub
        run_instr(7'b0010011, 3'b000, 1'b1, -1);   // addi with instr[30]=1
        run_instr(7'b1111111, 3'b000, 1'b0, -1);   // illegal
        run_instr(7'b0100011, 3'b010, 1'b0, -1);   // sw
        run_instr(7'b1101111, 3'b000, 1'b0, -1);   // jal
        for (int i = 0; i < 80; i++)
            run_instr(pick_op(), 3'($urandom), 1'($urandom), -1);

        // sw interrupted by reset while in MEMADR.
        bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        exp_q.push_back(model(FETCH, 7'b0100011, 3'b010, 1'b0, 1'b0));
        @(posedge clk); #1;
        exp_q.push_back(model(DECODE, 7'b0100011, 3'b010, 1'b0, 1'b0));
        @(posedge clk); #1;
        exp_q.push_back(model(MEMADR, 7'b0100011, 3'b010, 1'b0, 1'b0));
        #5;
        rst_n = 1'b0;
        #1;
        chk("async reset state_o",   32'(bus.state_o),   32'd0);
        chk("async reset mem_write", 32'(bus.mem_write), 32'd0);
        chk("async reset ir_write",  32'(bus.ir_write),  32'd1);
        chk("async reset adr_src",   32'(bus.adr_src),   32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset hold mem_write", 32'(bus.mem_write), 32'd0);
            chk("reset hold state_o",   32'(bus.state_o),   32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(7'b0100011, 3'b010, 1'b0, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, -1);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the RISC-V multicycle datapath. Decodes the instruction register's opcode/funct fields and steps a Moore FSM through fetch, decode, execute, memory and writeback. Drives every datapath select and write enable, including the 2-bit `result_src` consumed by the result mux that feeds the PC, the register file and the memory address path. Supports lw, sw, R-type, I-type ALU, jal and beq.

## Interface
- Parameters: none.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `op` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag, same cycle.
- `pc_write` out 1: PC enable; `pc_update | (branch & zero)`.
- `adr_src` out 1: 0 = PC, 1 = result to memory address.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction/old-PC register enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: 00 = alu_out, 01 = data register, 10 = alu_result.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1 register.
- `alu_src_b` out 2: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `state_o` out 4: current state, for debug and verification.

## Operation
- The FSM has these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
- FETCH → DECODE unconditionally.
- DECODE transitions on `op`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1101111 → JAL.
  - 1100011 → BEQ.
  - Any other opcode → FETCH. An illegal opcode raises no write enable.
- MEMADR → MEMREAD for lw, MEMWRITE for sw.
- Fixed transitions: MEMREAD → MEMWB. EXECUTER, EXECUTEI and JAL → ALUWB. MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Per-state outputs. Any signal not listed is 0, and alu_op defaults to 00.
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=00, result_src=10, pc_update=1.
  - DECODE: src_a=01, src_b=01, alu_op=00. Precomputes the branch/jump target.
  - MEMADR: src_a=10, src_b=01, alu_op=00.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - MEMWB: result_src=01, reg_write=1.
  - EXECUTER: src_a=10, src_b=00, alu_op=10.
  - EXECUTEI: src_a=10, src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1.
  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1.
- ALU decoder:
  - alu_op 00 → add.
  - alu_op 01 → sub.
  - alu_op 10, by funct3:
    - 000 → sub when `op[5] & funct7b5`, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - Any other funct3 → add.
- `imm_src` is a combinational function of `op`:
  - lw / I-type → 00.
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - Any other opcode → 00.

## Timing
- Reset: `rst_n` low forces state FETCH immediately, without waiting for a clock edge.
  - While in reset, outputs show FETCH values: pc_write=1, ir_write=1, all other write enables 0.
  - The datapath must hold the PC in reset so the FETCH pc_write does not take effect.
- Reset asserted mid-instruction abandons that instruction. No write enable from the interrupted state is asserted after reset asserts.
- Outputs are combinational from state. `pc_write` and `alu_control` also depend combinationally on inputs (`zero`; `op`/`funct3`/`funct7b5`).
- The state register updates on the rising edge of `clk`.
- Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal opcode 2.
- A new FETCH begins the cycle after the last state of each instruction.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the `state_t` enum, 4-bit encoding, with FETCH = 0;
  - opcode constants;
  - alu_op codes;
  - `alu_control` codes;
  - `result_src` / `alu_src_a` / `alu_src_b` encodings, shared with the result mux and the datapath muxes.
- Sub-module `alu_decoder`, purely combinational: (`alu_op`, `funct3`, `op[5]`, `funct7b5`) → `alu_control`.
- The FSM and `imm_src` decode live in the top module.

## Test plan
- Reset: hold `rst_n` low across edges → state_o=FETCH, ir_write=1, result_src=10, src_b=10, mem_write=0, reg_write=0.
- lw (op=0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. MEMWB has result_src=01, reg_write=1. imm_src=00 throughout.
- beq (op=1100011):
  - zero=1 in the BEQ state → pc_write=1, alu_control=001, result_src=00.
  - zero=0 → pc_write=0.
  - Both cases return to FETCH on the next cycle.
- R-type sub (funct3=000, funct7b5=1) → EXECUTER then ALUWB; alu_control=001 in EXECUTER.
- I-type with funct7b5=1 → alu_control=000, because op[5]=0.
- Illegal opcode 1111111 → DECODE → FETCH, with no reg_write or mem_write.
- sw → MEMWRITE asserts mem_write=1 with adr_src=1.
- Drop `rst_n` during MEMADR → state becomes FETCH asynchronously; mem_write is never asserted.
